seg7_scan_mux: RTL

- Parametrised multi-channel seven-segment scan driver; successor to the fixed 8-digit, single-word display driver used on the FPGA top level.
- Time-multiplexes NUM_DIGITS hex digits from one of NUM_CHANNELS input words, selected manually or by auto-rotation.
- Adds frame-coherent snapshots (no tearing), per-slot anti-ghost blanking, leading-zero suppression, a decimal-point mask and a freeze mode.
- Sits between the processor/debug words and the board's seg/an/dp pins; runs on the board clock.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_hex_decode.sv | 10 +
 rtl/seg7_scan_mux.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the seven-segment scan driver
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic int cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - hex nibble to active-low seven-segment pattern
module seg7_hex_decode (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);
   import seg7_pkg::*;

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multi-channel seven-segment scan driver with frame snapshots
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int NUM_CHANNELS  = 2,
   parameter int DIGIT_CYCLES  = 100000,
   parameter int BLANK_CYCLES  = 4,
   parameter int FRAMES_PER_CH = 256
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [4*NUM_DIGITS*NUM_CHANNELS-1:0]  data,
   input  logic [cw(NUM_CHANNELS)-1:0]           ch_sel,
   input  logic                                  auto_rotate,
   input  logic                                  blank_lz,
   input  logic [NUM_DIGITS-1:0]                 dp_mask,
   input  logic                                  freeze,
   output logic [6:0]                            seg,
   output logic [NUM_DIGITS-1:0]                 an,
   output logic                                  dp,
   output logic [cw(NUM_CHANNELS)-1:0]           cur_ch
);

   localparam int CW = cw(NUM_CHANNELS);
   localparam int DW = cw(NUM_DIGITS);
   localparam int PW = cw(DIGIT_CYCLES);
   localparam int FW = cw(FRAMES_PER_CH);
   localparam int WW = 4 * NUM_DIGITS;

   logic [PW-1:0]         prescaler_q, prescaler_d;
   logic [DW-1:0]         digit_idx_q, digit_idx_d;
   logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
   logic [WW-1:0]         snapshot_q, snapshot_d;
   logic [CW-1:0]         cur_ch_q, cur_ch_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  dp_q, dp_d;

   logic                  tick;
   logic                  frame_end;
   logic [3:0]            nibble;
   logic [6:0]            hex_seg;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  upper_zero;

   always_comb begin
      tick        = (prescaler_q == PW'(DIGIT_CYCLES - 1));
      frame_end   = tick && (digit_idx_q == DW'(NUM_DIGITS - 1));
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
      digit_idx_d = digit_idx_q;
      frame_cnt_d = frame_cnt_q;
      cur_ch_d    = cur_ch_q;
      snapshot_d  = snapshot_q;
      if (tick) begin
         digit_idx_d = frame_end ? '0 : digit_idx_q + 1'b1;
      end
      // Channel and snapshot move together so a frame never mixes two words.
      if (frame_end && !freeze) begin
         if (auto_rotate) begin
            if (frame_cnt_q == FW'(FRAMES_PER_CH - 1)) begin
               frame_cnt_d = '0;
               cur_ch_d    = (cur_ch_q == CW'(NUM_CHANNELS - 1)) ? '0 : cur_ch_q + 1'b1;
            end else begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end else begin
            cur_ch_d = (int'(ch_sel) >= NUM_CHANNELS) ? '0 : ch_sel;
         end
         snapshot_d = data[int'(cur_ch_d)*WW +: WW];
      end
   end

   assign nibble = snapshot_q[{digit_idx_q, 2'b00} +: 4];

   seg7_hex_decode u_hex_decode (
      .nibble_i (nibble),
      .seg_o    (hex_seg)
   );

   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      // Digit 0 is never suppressed, so an all-zero word still shows "0".
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         upper_zero  = upper_zero && (snapshot_q[4*i +: 4] == 4'h0);
         lz_blank[i] = blank_lz && upper_zero;
      end
      seg_d = lz_blank[digit_idx_q] ? SEG_BLANK : hex_seg;
      an_d  = (prescaler_q < PW'(BLANK_CYCLES)) ? '1 : ~(NUM_DIGITS'(1) << digit_idx_q);
      dp_d  = ~dp_mask[digit_idx_q];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler_q <= '0;
         digit_idx_q <= '0;
         frame_cnt_q <= '0;
         snapshot_q  <= '0;
         cur_ch_q    <= '0;
         seg_q       <= SEG_BLANK;
         an_q        <= '1;
         dp_q        <= 1'b1;
      end else begin
         prescaler_q <= prescaler_d;
         digit_idx_q <= digit_idx_d;
         frame_cnt_q <= frame_cnt_d;
         snapshot_q  <= snapshot_d;
         cur_ch_q    <= cur_ch_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         dp_q        <= dp_d;
      end
   end

   assign seg    = seg_q;
   assign an     = an_q;
   assign dp     = dp_q;
   assign cur_ch = cur_ch_q;

endmodule
